// File: rtl/rob_retire.sv
// rtl/rob_retire.sv - 16-entry reorder buffer with 2-wide in-order retirement
module rob_retire #(
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4,
    parameter int PREG_W = 6,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alloc_valid_1,
    input  logic [PREG_W-1:0] alloc_dest_1,
    input  logic [PREG_W-1:0] alloc_old_dest_1,
    input  logic [PC_W-1:0]   alloc_pc_1,
    input  logic              alloc_valid_2,
    input  logic [PREG_W-1:0] alloc_dest_2,
    input  logic [PREG_W-1:0] alloc_old_dest_2,
    input  logic [PC_W-1:0]   alloc_pc_2,
    output logic              alloc_ready,
    output logic [PTR_W-1:0]  alloc_idx_1,
    output logic [PTR_W-1:0]  alloc_idx_2,
    input  logic              cmpl_valid_1,
    input  logic [PTR_W-1:0]  cmpl_idx_1,
    input  logic              cmpl_valid_2,
    input  logic [PTR_W-1:0]  cmpl_idx_2,
    output logic              ret_valid_1,
    output logic              ret_valid_2,
    output logic [PREG_W-1:0] ret_dest_1,
    output logic [PREG_W-1:0] ret_dest_2,
    output logic [PREG_W-1:0] ret_old_dest_1,
    output logic [PREG_W-1:0] ret_old_dest_2,
    output logic [PC_W-1:0]   ret_pc_1,
    output logic [PC_W-1:0]   ret_pc_2,
    output logic [PTR_W:0]    count,
    output logic              empty
);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  v_q, v_d, done_q, done_d;
    logic [PREG_W-1:0] dest_q [DEPTH];
    logic [PREG_W-1:0] dest_d [DEPTH];
    logic [PREG_W-1:0] old_q  [DEPTH];
    logic [PREG_W-1:0] old_d  [DEPTH];
    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [PC_W-1:0]   pc_d   [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, head_nxt;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              ret_valid_1_q, ret_valid_1_d, ret_valid_2_q, ret_valid_2_d;
    logic [PREG_W-1:0] ret_dest_1_q, ret_dest_1_d, ret_dest_2_q, ret_dest_2_d;
    logic [PREG_W-1:0] ret_old_1_q, ret_old_1_d, ret_old_2_q, ret_old_2_d;
    logic [PC_W-1:0]   ret_pc_1_q, ret_pc_1_d, ret_pc_2_q, ret_pc_2_d;

    logic acc_1, acc_2, r1, r2;

    // Readiness comes from the registered count only, so same-cycle retires never raise it
    assign alloc_ready = count_q <= CNT_W'(DEPTH - 2);
    assign empty       = count_q == '0;
    assign count       = count_q;
    assign alloc_idx_1 = tail_q;
    assign alloc_idx_2 = tail_q + PTR_W'(alloc_valid_1);
    assign acc_1       = alloc_valid_1 & alloc_ready;
    assign acc_2       = alloc_valid_2 & alloc_ready;
    assign head_nxt    = head_q + PTR_W'(1);
    assign r1          = v_q[head_q] & done_q[head_q];
    assign r2          = r1 & v_q[head_nxt] & done_q[head_nxt];

    assign ret_valid_1    = ret_valid_1_q;
    assign ret_valid_2    = ret_valid_2_q;
    assign ret_dest_1     = ret_dest_1_q;
    assign ret_dest_2     = ret_dest_2_q;
    assign ret_old_dest_1 = ret_old_1_q;
    assign ret_old_dest_2 = ret_old_2_q;
    assign ret_pc_1       = ret_pc_1_q;
    assign ret_pc_2       = ret_pc_2_q;

    // Next state: completion, then retire, then allocation; flush overrides everything
    always_comb begin
        v_d           = v_q;
        done_d        = done_q;
        dest_d        = dest_q;
        old_d         = old_q;
        pc_d          = pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        ret_valid_1_d = 1'b0;
        ret_valid_2_d = 1'b0;
        ret_dest_1_d  = '0;
        ret_dest_2_d  = '0;
        ret_old_1_d   = '0;
        ret_old_2_d   = '0;
        ret_pc_1_d    = '0;
        ret_pc_2_d    = '0;
        if (flush) begin
            v_d     = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Only entries already valid can complete; same-cycle allocations see v_q=0
            if (cmpl_valid_1 && v_q[cmpl_idx_1]) done_d[cmpl_idx_1] = 1'b1;
            if (cmpl_valid_2 && v_q[cmpl_idx_2]) done_d[cmpl_idx_2] = 1'b1;
            if (r1) begin
                v_d[head_q]    = 1'b0;
                done_d[head_q] = 1'b0;
                ret_valid_1_d  = 1'b1;
                ret_dest_1_d   = dest_q[head_q];
                ret_old_1_d    = old_q[head_q];
                ret_pc_1_d     = pc_q[head_q];
            end
            if (r2) begin
                v_d[head_nxt]    = 1'b0;
                done_d[head_nxt] = 1'b0;
                ret_valid_2_d    = 1'b1;
                ret_dest_2_d     = dest_q[head_nxt];
                ret_old_2_d      = old_q[head_nxt];
                ret_pc_2_d       = pc_q[head_nxt];
            end
            // Allocation targets free slots only (at least two free when ready)
            if (acc_1) begin
                v_d[alloc_idx_1]    = 1'b1;
                done_d[alloc_idx_1] = 1'b0;
                dest_d[alloc_idx_1] = alloc_dest_1;
                old_d[alloc_idx_1]  = alloc_old_dest_1;
                pc_d[alloc_idx_1]   = alloc_pc_1;
            end
            if (acc_2) begin
                v_d[alloc_idx_2]    = 1'b1;
                done_d[alloc_idx_2] = 1'b0;
                dest_d[alloc_idx_2] = alloc_dest_2;
                old_d[alloc_idx_2]  = alloc_old_dest_2;
                pc_d[alloc_idx_2]   = alloc_pc_2;
            end
            head_d  = head_q + PTR_W'(r1) + PTR_W'(r2);
            tail_d  = tail_q + PTR_W'(acc_1) + PTR_W'(acc_2);
            count_d = count_q + CNT_W'(acc_1) + CNT_W'(acc_2) - CNT_W'(r1) - CNT_W'(r2);
        end
    end

    // Control state and retire outputs, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q           <= '0;
            done_q        <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            ret_valid_1_q <= 1'b0;
            ret_valid_2_q <= 1'b0;
            ret_dest_1_q  <= '0;
            ret_dest_2_q  <= '0;
            ret_old_1_q   <= '0;
            ret_old_2_q   <= '0;
            ret_pc_1_q    <= '0;
            ret_pc_2_q    <= '0;
        end else begin
            v_q           <= v_d;
            done_q        <= done_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            ret_valid_1_q <= ret_valid_1_d;
            ret_valid_2_q <= ret_valid_2_d;
            ret_dest_1_q  <= ret_dest_1_d;
            ret_dest_2_q  <= ret_dest_2_d;
            ret_old_1_q   <= ret_old_1_d;
            ret_old_2_q   <= ret_old_2_d;
            ret_pc_1_q    <= ret_pc_1_d;
            ret_pc_2_q    <= ret_pc_2_d;
        end
    end

    // Entry payload; only read while the matching v bit is set, so no reset needed
    always_ff @(posedge clk) begin
        dest_q <= dest_d;
        old_q  <= old_d;
        pc_q   <= pc_d;
    end
endmodule

// File: tb/tb_rob_retire.sv
// tb/tb_rob_retire.sv - directed vector bench for rob_retire
module tb_rob_retire;
    logic        clk, rst_n, flush;
    logic        alloc_valid_1, alloc_valid_2, cmpl_valid_1, cmpl_valid_2;
    logic [5:0]  alloc_dest_1, alloc_old_dest_1, alloc_dest_2, alloc_old_dest_2;
    logic [31:0] alloc_pc_1, alloc_pc_2;
    logic [3:0]  cmpl_idx_1, cmpl_idx_2, alloc_idx_1, alloc_idx_2;
    logic        alloc_ready, ret_valid_1, ret_valid_2, empty;
    logic [5:0]  ret_dest_1, ret_dest_2, ret_old_dest_1, ret_old_dest_2;
    logic [31:0] ret_pc_1, ret_pc_2;
    logic [4:0]  count;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_ret = 0;
    logic [31:0] exp_pc;
    bit          watch_en = 0;

    rob_retire dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid_1(alloc_valid_1), .alloc_dest_1(alloc_dest_1),
        .alloc_old_dest_1(alloc_old_dest_1), .alloc_pc_1(alloc_pc_1),
        .alloc_valid_2(alloc_valid_2), .alloc_dest_2(alloc_dest_2),
        .alloc_old_dest_2(alloc_old_dest_2), .alloc_pc_2(alloc_pc_2),
        .alloc_ready(alloc_ready), .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
        .cmpl_valid_1(cmpl_valid_1), .cmpl_idx_1(cmpl_idx_1),
        .cmpl_valid_2(cmpl_valid_2), .cmpl_idx_2(cmpl_idx_2),
        .ret_valid_1(ret_valid_1), .ret_valid_2(ret_valid_2),
        .ret_dest_1(ret_dest_1), .ret_dest_2(ret_dest_2),
        .ret_old_dest_1(ret_old_dest_1), .ret_old_dest_2(ret_old_dest_2),
        .ret_pc_1(ret_pc_1), .ret_pc_2(ret_pc_2),
        .count(count), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        av1; logic [5:0] d1; logic [5:0] od1; logic [31:0] pc1;
        logic        av2; logic [5:0] d2; logic [5:0] od2; logic [31:0] pc2;
        logic        cv1; logic [3:0] ci1; logic cv2; logic [3:0] ci2;
        logic [3:0]  x_idx1; logic [3:0] x_idx2; logic x_rdy; logic [4:0] x_cnt;
        logic        x_rv1; logic x_rv2; logic [5:0] x_old1; logic [5:0] x_old2;
        logic [31:0] x_pc1; logic [31:0] x_pc2;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] old_of(input logic [31:0] pc);
        return pc[7:2];
    endfunction

    function automatic logic [5:0] dest_of(input logic [31:0] pc);
        return pc[7:2] + 6'd32;
    endfunction

    task automatic drive_idle();
        flush = 0; alloc_valid_1 = 0; alloc_valid_2 = 0;
        alloc_dest_1 = 0; alloc_old_dest_1 = 0; alloc_pc_1 = 0;
        alloc_dest_2 = 0; alloc_old_dest_2 = 0; alloc_pc_2 = 0;
        cmpl_valid_1 = 0; cmpl_idx_1 = 0; cmpl_valid_2 = 0; cmpl_idx_2 = 0;
    endtask

    task automatic alloc1(input logic [31:0] pc);
        alloc_valid_1 = 1; alloc_pc_1 = pc; alloc_old_dest_1 = old_of(pc); alloc_dest_1 = dest_of(pc);
    endtask

    task automatic alloc2(input logic [31:0] pc);
        alloc_valid_2 = 1; alloc_pc_2 = pc; alloc_old_dest_2 = old_of(pc); alloc_dest_2 = dest_of(pc);
    endtask

    // Retire stream must follow exp_pc in strict order; idle slots carry zero data
    task automatic watch();
        if (!watch_en) return;
        if (ret_valid_2) chk("ret2_implies_ret1", 32'(ret_valid_1), 32'd1);
        if (ret_valid_1) begin
            chk("ret_pc_1", ret_pc_1, exp_pc);
            chk("ret_old_1", 32'(ret_old_dest_1), 32'(old_of(exp_pc)));
            chk("ret_dest_1", 32'(ret_dest_1), 32'(dest_of(exp_pc)));
            exp_pc = exp_pc + 32'd4; n_ret++;
        end else begin
            chk("ret_pc_1_zero", ret_pc_1, 32'd0);
        end
        if (ret_valid_2) begin
            chk("ret_pc_2", ret_pc_2, exp_pc);
            chk("ret_old_2", 32'(ret_old_dest_2), 32'(old_of(exp_pc)));
            chk("ret_dest_2", 32'(ret_dest_2), 32'(dest_of(exp_pc)));
            exp_pc = exp_pc + 32'd4; n_ret++;
        end else begin
            chk("ret_old_2_zero", 32'(ret_old_dest_2), 32'd0);
        end
    endtask

    // One clock: inputs held across the edge, outputs sampled 1ns after, next inputs idle at negedge
    task automatic step();
        @(posedge clk);
        #1;
        watch();
        @(negedge clk);
        drive_idle();
    endtask

    // Complete every index two per cycle, then idle; bounded number of cycles
    task automatic drain(input int n_exp);
        int n0;
        n0 = n_ret;
        for (int j = 0; j < 8; j++) begin
            cmpl_valid_1 = 1; cmpl_idx_1 = 4'(2 * j);
            cmpl_valid_2 = 1; cmpl_idx_2 = 4'(2 * j + 1);
            step();
        end
        for (int k = 0; k < 10; k++) step();
        chk("drain_retired", 32'(n_ret - n0), 32'(n_exp));
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b1,6'd32,6'd5,32'h0,   1'b1,6'd33,6'd6,32'h4,   1'b0,4'd0,1'b0,4'd0, 4'd0,4'd1,1'b1,5'd2, 1'b0,1'b0,6'd0,6'd0,32'h0,32'h0};
        vecs[1]  = '{1'b0, 1'b0,6'd0,6'd0,32'h0,    1'b0,6'd0,6'd0,32'h0,    1'b1,4'd1,1'b0,4'd0, 4'd2,4'd2,1'b1,5'd2, 1'b0,1'b0,6'd0,6'd0,32'h0,32'h0};
        vecs[2]  = '{1'b0, 1'b0,6'd0,6'd0,32'h0,    1'b0,6'd0,6'd0,32'h0,    1'b1,4'd0,1'b0,4'd0, 4'd2,4'd2,1'b1,5'd2, 1'b0,1'b0,6'd0,6'd0,32'h0,32'h0};
        vecs[3]  = '{1'b0, 1'b0,6'd0,6'd0,32'h0,    1'b0,6'd0,6'd0,32'h0,    1'b0,4'd0,1'b0,4'd0, 4'd2,4'd2,1'b1,5'd0, 1'b1,1'b1,6'd5,6'd6,32'h0,32'h4};
        vecs[4]  = '{1'b0, 1'b1,6'd10,6'd20,32'h100, 1'b1,6'd11,6'd21,32'h104, 1'b1,4'd2,1'b0,4'd0, 4'd2,4'd3,1'b1,5'd2, 1'b0,1'b0,6'd0,6'd0,32'h0,32'h0};
        vecs[5]  = '{1'b0, 1'b1,6'd12,6'd22,32'h108, 1'b1,6'd13,6'd23,32'h10c, 1'b0,4'd0,1'b0,4'd0, 4'd4,4'd5,1'b1,5'd4, 1'b0,1'b0,6'd0,6'd0,32'h0,32'h0};
        vecs[6]  = '{1'b0, 1'b0,6'd0,6'd0,32'h0,    1'b0,6'd0,6'd0,32'h0,    1'b1,4'd5,1'b0,4'd0, 4'd6,4'd6,1'b1,5'd4, 1'b0,1'b0,6'd0,6'd0,32'h0,32'h0};
        vecs[7]  = '{1'b0, 1'b0,6'd0,6'd0,32'h0,    1'b0,6'd0,6'd0,32'h0,    1'b1,4'd4,1'b1,4'd9, 4'd6,4'd6,1'b1,5'd4, 1'b0,1'b0,6'd0,6'd0,32'h0,32'h0};
        vecs[8]  = '{1'b0, 1'b0,6'd0,6'd0,32'h0,    1'b0,6'd0,6'd0,32'h0,    1'b1,4'd3,1'b1,4'd3, 4'd6,4'd6,1'b1,5'd4, 1'b0,1'b0,6'd0,6'd0,32'h0,32'h0};
        vecs[9]  = '{1'b0, 1'b0,6'd0,6'd0,32'h0,    1'b0,6'd0,6'd0,32'h0,    1'b1,4'd2,1'b0,4'd0, 4'd6,4'd6,1'b1,5'd4, 1'b0,1'b0,6'd0,6'd0,32'h0,32'h0};
        vecs[10] = '{1'b0, 1'b0,6'd0,6'd0,32'h0,    1'b0,6'd0,6'd0,32'h0,    1'b0,4'd0,1'b0,4'd0, 4'd6,4'd6,1'b1,5'd2, 1'b1,1'b1,6'd20,6'd21,32'h100,32'h104};
        vecs[11] = '{1'b0, 1'b0,6'd0,6'd0,32'h0,    1'b0,6'd0,6'd0,32'h0,    1'b0,4'd0,1'b0,4'd0, 4'd6,4'd6,1'b1,5'd0, 1'b1,1'b1,6'd22,6'd23,32'h108,32'h10c};

        rst_n = 0;
        drive_idle();
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(alloc_ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ret_valid", 32'({ret_valid_1, ret_valid_2}), 32'd0);
        rst_n = 1;

        // Table vectors: basic dual retire, out-of-order completion, invalid/same-cycle completions
        for (int i = 0; i < NV; i++) begin
            flush = vecs[i].fl;
            alloc_valid_1 = vecs[i].av1; alloc_dest_1 = vecs[i].d1; alloc_old_dest_1 = vecs[i].od1; alloc_pc_1 = vecs[i].pc1;
            alloc_valid_2 = vecs[i].av2; alloc_dest_2 = vecs[i].d2; alloc_old_dest_2 = vecs[i].od2; alloc_pc_2 = vecs[i].pc2;
            cmpl_valid_1 = vecs[i].cv1; cmpl_idx_1 = vecs[i].ci1; cmpl_valid_2 = vecs[i].cv2; cmpl_idx_2 = vecs[i].ci2;
            #1;
            chk($sformatf("v%0d_idx1", i), 32'(alloc_idx_1), 32'(vecs[i].x_idx1));
            chk($sformatf("v%0d_idx2", i), 32'(alloc_idx_2), 32'(vecs[i].x_idx2));
            chk($sformatf("v%0d_ready", i), 32'(alloc_ready), 32'(vecs[i].x_rdy));
            step();
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].x_cnt));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].x_cnt == 5'd0));
            chk($sformatf("v%0d_rv1", i), 32'(ret_valid_1), 32'(vecs[i].x_rv1));
            chk($sformatf("v%0d_rv2", i), 32'(ret_valid_2), 32'(vecs[i].x_rv2));
            chk($sformatf("v%0d_old1", i), 32'(ret_old_dest_1), 32'(vecs[i].x_old1));
            chk($sformatf("v%0d_old2", i), 32'(ret_old_dest_2), 32'(vecs[i].x_old2));
            chk($sformatf("v%0d_pc1", i), ret_pc_1, vecs[i].x_pc1);
            chk($sformatf("v%0d_pc2", i), ret_pc_2, vecs[i].x_pc2);
        end

        // Fill from head=tail=6 with 8 pairs, then a dropped extra allocation
        watch_en = 1;
        exp_pc = 32'h200;
        for (int k = 0; k < 8; k++) begin
            alloc1(32'h200 + 32'(8 * k));
            alloc2(32'h204 + 32'(8 * k));
            #1;
            chk("fill_idx1", 32'(alloc_idx_1), 32'((6 + 2 * k) % 16));
            chk("fill_idx2", 32'(alloc_idx_2), 32'((7 + 2 * k) % 16));
            chk("fill_ready", 32'(alloc_ready), 32'd1);
            chk("fill_count_pre", 32'(count), 32'(2 * k));
            step();
        end
        chk("full_count", 32'(count), 32'd16);
        chk("full_ready", 32'(alloc_ready), 32'd0);
        chk("full_empty", 32'(empty), 32'd0);
        alloc1(32'h2f0);
        alloc2(32'h2f4);
        step();
        #1;
        chk("drop_count", 32'(count), 32'd16);
        chk("drop_tail", 32'(alloc_idx_1), 32'd6);
        chk("drop_tail2", 32'(alloc_idx_2), 32'd6);
        drain(16);

        // Same-edge allocate and retire at count=14
        exp_pc = 32'h300;
        for (int k = 0; k < 7; k++) begin
            alloc1(32'h300 + 32'(8 * k));
            alloc2(32'h304 + 32'(8 * k));
            step();
        end
        cmpl_valid_1 = 1; cmpl_idx_1 = 4'd6;
        cmpl_valid_2 = 1; cmpl_idx_2 = 4'd7;
        step();
        begin
            int n0;
            alloc1(32'h338);
            alloc2(32'h33c);
            #1;
            chk("se_idx1", 32'(alloc_idx_1), 32'd4);
            chk("se_idx2", 32'(alloc_idx_2), 32'd5);
            chk("se_ready", 32'(alloc_ready), 32'd1);
            chk("se_count_pre", 32'(count), 32'd14);
            n0 = n_ret;
            step();
            chk("se_count_post", 32'(count), 32'd14);
            chk("se_retired", 32'(n_ret - n0), 32'd2);
        end
        drain(14);

        // Wrap: single alloc/complete/retire, alternating slots, head 6 -> 15
        exp_pc = 32'h400;
        for (int i = 0; i < 25; i++) begin
            if (i % 2 == 0) begin
                alloc1(32'h400 + 32'(4 * i));
                #1;
                chk("wrap_idx1", 32'(alloc_idx_1), 32'((6 + i) % 16));
            end else begin
                alloc2(32'h400 + 32'(4 * i));
                #1;
                chk("wrap_idx2_alone", 32'(alloc_idx_2), 32'((6 + i) % 16));
            end
            step();
            cmpl_valid_1 = 1; cmpl_idx_1 = 4'((6 + i) % 16);
            step();
            step();
            chk("wrap_rv1", 32'(ret_valid_1), 32'd1);
            chk("wrap_rv2", 32'(ret_valid_2), 32'd0);
        end
        alloc1(32'h464);
        alloc2(32'h468);
        #1;
        chk("span_idx1", 32'(alloc_idx_1), 32'd15);
        chk("span_idx2", 32'(alloc_idx_2), 32'd0);
        step();
        cmpl_valid_1 = 1; cmpl_idx_1 = 4'd15;
        cmpl_valid_2 = 1; cmpl_idx_2 = 4'd0;
        step();
        step();
        chk("span_rv1", 32'(ret_valid_1), 32'd1);
        chk("span_rv2", 32'(ret_valid_2), 32'd1);
        chk("span_count", 32'(count), 32'd0);

        // Flush with 5 entries, head pair done: flush beats the pending retire
        exp_pc = 32'h500;
        alloc1(32'h500); alloc2(32'h504); step();
        alloc1(32'h508); alloc2(32'h50c); step();
        alloc1(32'h510); step();
        cmpl_valid_1 = 1; cmpl_idx_1 = 4'd1;
        cmpl_valid_2 = 1; cmpl_idx_2 = 4'd2;
        step();
        chk("pre_flush_count", 32'(count), 32'd5);
        chk("pre_flush_rv1", 32'(ret_valid_1), 32'd0);
        flush = 1;
        alloc1(32'h514);
        step();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_ready", 32'(alloc_ready), 32'd1);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_rv", 32'({ret_valid_1, ret_valid_2}), 32'd0);
        #1;
        chk("flush_tail", 32'(alloc_idx_1), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_flush_rv", 32'({ret_valid_1, ret_valid_2}), 32'd0);
        end

        // Async reset while a retire pulse is on the outputs
        exp_pc = 32'h600;
        alloc1(32'h600); alloc2(32'h604); step();
        cmpl_valid_1 = 1; cmpl_idx_1 = 4'd0;
        cmpl_valid_2 = 1; cmpl_idx_2 = 4'd1;
        step();
        step();
        chk("pre_rst_rv1", 32'(ret_valid_1), 32'd1);
        chk("pre_rst_rv2", 32'(ret_valid_2), 32'd1);
        #1 rst_n = 0;
        #1;
        chk("arst_rv", 32'({ret_valid_1, ret_valid_2}), 32'd0);
        chk("arst_pc1", ret_pc_1, 32'd0);
        chk("arst_old1", 32'(ret_old_dest_1), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_ready", 32'(alloc_ready), 32'd1);
        chk("arst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_rv", 32'({ret_valid_1, ret_valid_2}), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
